// File: rtl/bist_pattern_misr_pkg.sv
// Shared types and constants for the pattern-generator / signature-compactor BIST wrapper.
package bist_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } bist_state_t;

    // x^7 + x^6 + 1: feedback taps are bits 6 and 5 of the 7-bit stimulus LFSR
    localparam int          LFSR_TAP_A        = 6;
    localparam int          LFSR_TAP_B        = 5;
    localparam logic [15:0] DEFAULT_MISR_POLY = 16'hB400;
    localparam logic [6:0]  DEFAULT_LFSR_SEED = 7'h01;

endpackage

// File: rtl/bist_pattern_misr_misr.sv
// Galois multiple-input signature register; response is zero-extended into the low bits.
module bist_misr
    import bist_pkg::*;
#(
    parameter int               SIG_W  = 16,
    parameter int               RESP_W = 2,
    parameter logic [SIG_W-1:0] POLY   = SIG_W'(DEFAULT_MISR_POLY)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              enable_i,
    input  logic [RESP_W-1:0] resp_i,
    output logic [SIG_W-1:0]  sig_o,
    output logic [SIG_W-1:0]  sig_next_o
);

    logic [SIG_W-1:0] sig_q;
    logic [SIG_W-1:0] sig_d;

    // Next signature: clear wins over compaction.
    always_comb begin
        sig_d = sig_q;
        if (clear_i) begin
            sig_d = '0;
        end else if (enable_i) begin
            sig_d = (sig_q >> 1) ^ (sig_q[0] ? POLY : '0) ^ SIG_W'(resp_i);
        end else begin
            sig_d = sig_q;
        end
    end

    // Signature register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig_o      = sig_q;
    assign sig_next_o = sig_d;

endmodule

// File: rtl/bist_pattern_misr.sv
// BIST wrapper: drives LFSR patterns into a 7-in/2-out CUT and compacts its responses.
module bist_pattern_misr
    import bist_pkg::*;
#(
    parameter int               PAT_W      = 7,
    parameter int               RESP_W     = 2,
    parameter int               SIG_W      = 16,
    parameter int               N_PATTERNS = 127,
    parameter logic [PAT_W-1:0] LFSR_SEED  = PAT_W'(DEFAULT_LFSR_SEED),
    parameter logic [SIG_W-1:0] MISR_POLY  = SIG_W'(DEFAULT_MISR_POLY),
    parameter logic [SIG_W-1:0] GOLDEN     = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic [PAT_W-1:0]  pat_o,
    input  logic [RESP_W-1:0] resp_i,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [SIG_W-1:0]  signature,
    output logic [15:0]       pat_cnt
);

    localparam logic [15:0] LAST_CNT = 16'(N_PATTERNS - 1);

    bist_state_t      state_q, state_d;
    logic [PAT_W-1:0] lfsr_q, lfsr_d;
    logic [15:0]      cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             misr_clear_s;
    logic             misr_en_s;
    logic [SIG_W-1:0] sig_next_s;
    logic [PAT_W-1:0] lfsr_next_s;

    // The LFSR register doubles as pat_o, so it is held at zero outside RUN.
    assign lfsr_next_s = {lfsr_q[PAT_W-2:0], lfsr_q[LFSR_TAP_A] ^ lfsr_q[LFSR_TAP_B]};

    // Next-state and datapath control; abort outranks start and completion.
    always_comb begin
        state_d      = state_q;
        lfsr_d       = lfsr_q;
        cnt_d        = cnt_q;
        misr_clear_s = 1'b0;
        misr_en_s    = 1'b0;
        case (state_q)
            IDLE: begin
                if (abort) begin
                    lfsr_d       = '0;
                    cnt_d        = 16'd0;
                    misr_clear_s = 1'b1;
                end else if (start) begin
                    state_d      = RUN;
                    lfsr_d       = LFSR_SEED;
                    cnt_d        = 16'd0;
                    misr_clear_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d      = IDLE;
                    lfsr_d       = '0;
                    cnt_d        = 16'd0;
                    misr_clear_s = 1'b1;
                end else begin
                    misr_en_s = 1'b1;
                    cnt_d     = cnt_q + 16'd1;
                    if (cnt_q == LAST_CNT) begin
                        state_d = DONE;
                        lfsr_d  = '0;
                    end else begin
                        lfsr_d  = lfsr_next_s;
                    end
                end
            end
            DONE: begin
                if (abort) begin
                    state_d      = IDLE;
                    cnt_d        = 16'd0;
                    misr_clear_s = 1'b1;
                end else if (start) begin
                    state_d      = RUN;
                    lfsr_d       = LFSR_SEED;
                    cnt_d        = 16'd0;
                    misr_clear_s = 1'b1;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d      = IDLE;
                lfsr_d       = '0;
                cnt_d        = 16'd0;
                misr_clear_s = 1'b1;
            end
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
        pass_d = done_d && (sig_next_s == GOLDEN);
    end

    // Control and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lfsr_q  <= '0;
            cnt_q   <= 16'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    bist_misr #(
        .SIG_W  (SIG_W),
        .RESP_W (RESP_W),
        .POLY   (MISR_POLY)
    ) u_misr (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_i    (misr_clear_s),
        .enable_i   (misr_en_s),
        .resp_i     (resp_i),
        .sig_o      (signature),
        .sig_next_o (sig_next_s)
    );

    assign pat_o   = lfsr_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign pass    = pass_q;
    assign pat_cnt = cnt_q;

endmodule

// File: tb/tb_bist_pattern_misr.sv
// Self-checking bench for bist_pattern_misr: table vectors, random responses and a CUT model.
module tb_bist_pattern_misr;

    localparam int N_D = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    int          n_chk  = 0;
    int          n_pass = 0;

    // Instance A: default parameters, tb-driven responses
    logic        start_a, abort_a;
    logic [1:0]  resp_a;
    logic [6:0]  pat_a;
    logic        busy_a, done_a, pass_a;
    logic [15:0] sig_a, cnt_a;
    // Instance B: N=2, GOLDEN=B402
    logic        start_b, abort_b;
    logic [1:0]  resp_b;
    logic [6:0]  pat_b;
    logic        busy_b, done_b, pass_b;
    logic [15:0] sig_b, cnt_b;
    // Instance C: N=1
    logic        start_c, abort_c;
    logic [1:0]  resp_c;
    logic [6:0]  pat_c;
    logic        busy_c, done_c, pass_c;
    logic [15:0] sig_c, cnt_c;
    // Instance D: behavioural CUT in the loop
    logic        start_d, abort_d, fault_d;
    logic [1:0]  resp_d;
    logic [6:0]  pat_d;
    logic        busy_d, done_d, pass_d;
    logic [15:0] sig_d, cnt_d;

    function automatic logic [6:0] lfsr_step(input logic [6:0] x);
        return {x[5:0], x[6] ^ x[5]};
    endfunction

    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [1:0] r);
        return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000) ^ {14'd0, r};
    endfunction

    function automatic logic [1:0] cut_fn(input logic [6:0] x);
        logic [1:0] y;
        y[0] = (x[0] & x[1]) ^ (x[2] | x[3]) ^ x[6];
        y[1] = (x[4] ^ x[5]) | (x[0] & ~x[6]) | (x[3] & x[2]);
        return y;
    endfunction

    function automatic logic [15:0] model_sig(input int n, input logic flip);
        logic [6:0]  l;
        logic [15:0] s;
        l = 7'h01;
        s = 16'h0000;
        for (int i = 0; i < n; i++) begin
            s = misr_step(s, cut_fn(l) ^ {1'b0, flip});
            l = lfsr_step(l);
        end
        return s;
    endfunction

    localparam logic [15:0] GOLDEN_D = model_sig(N_D, 1'b0);

    assign resp_d = cut_fn(pat_d) ^ {1'b0, fault_d};

    bist_pattern_misr dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .pat_o(pat_a),
        .resp_i(resp_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .signature(sig_a), .pat_cnt(cnt_a));

    bist_pattern_misr #(.N_PATTERNS(2), .GOLDEN(16'hB402)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .pat_o(pat_b),
        .resp_i(resp_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .signature(sig_b), .pat_cnt(cnt_b));

    bist_pattern_misr #(.N_PATTERNS(1), .GOLDEN(16'h0003)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .abort(abort_c), .pat_o(pat_c),
        .resp_i(resp_c), .busy(busy_c), .done(done_c), .pass(pass_c),
        .signature(sig_c), .pat_cnt(cnt_c));

    bist_pattern_misr #(.N_PATTERNS(N_D), .GOLDEN(GOLDEN_D)) dut_d (
        .clk(clk), .rst_n(rst_n), .start(start_d), .abort(abort_d), .pat_o(pat_d),
        .resp_i(resp_d), .busy(busy_d), .done(done_d), .pass(pass_d),
        .signature(sig_d), .pat_cnt(cnt_d));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [1:0]  r0;
        logic [1:0]  r1;
        logic [15:0] sig;
        logic        p;
    } vec_t;

    vec_t        tbl [6];
    logic [1:0]  rnd [127];
    logic [127:0] seen;
    logic [6:0]  exp_pat;
    logic [15:0] exp_sig;

    initial begin
        tbl[0] = '{2'b01, 2'b10, 16'hB402, 1'b1};
        tbl[1] = '{2'b00, 2'b00, 16'h0000, 1'b0};
        tbl[2] = '{2'b11, 2'b11, 16'hB402, 1'b1};
        tbl[3] = '{2'b10, 2'b01, 16'h0000, 1'b0};
        tbl[4] = '{2'b01, 2'b00, 16'hB400, 1'b0};
        tbl[5] = '{2'b10, 2'b11, 16'h0002, 1'b0};

        rst_n   = 1'b0;
        start_a = 1'b0; abort_a = 1'b0; resp_a = 2'b00;
        start_b = 1'b0; abort_b = 1'b0; resp_b = 2'b00;
        start_c = 1'b0; abort_c = 1'b0; resp_c = 2'b00;
        start_d = 1'b0; abort_d = 1'b0; fault_d = 1'b0;
        #12;
        chk("rst_pat", 32'(pat_a), 32'h0);
        chk("rst_busy", 32'(busy_a), 32'h0);
        chk("rst_done", 32'(done_a), 32'h0);
        chk("rst_pass", 32'(pass_a), 32'h0);
        chk("rst_sig", 32'(sig_a), 32'h0);
        chk("rst_cnt", 32'(cnt_a), 32'h0);
        rst_n = 1'b1;
        tick();

        // Full pattern sequence with zero responses; a start pulse mid-run must be ignored
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        exp_pat = 7'h01;
        seen    = '0;
        for (int k = 0; k < 127; k++) begin
            chk("pat_seq", 32'(pat_a), 32'(exp_pat));
            if (k == 0)   chk("run_busy", 32'(busy_a), 32'h1);
            if (k == 11)  chk("start_ignored_cnt", 32'(cnt_a), 32'd11);
            if (k == 126) chk("done_not_early", 32'(done_a), 32'h0);
            seen[pat_a] = 1'b1;
            exp_pat = lfsr_step(exp_pat);
            start_a = (k == 10);
            tick();
        end
        start_a = 1'b0;
        chk("seq_done", 32'(done_a), 32'h1);
        chk("seq_busy", 32'(busy_a), 32'h0);
        chk("seq_sig", 32'(sig_a), 32'h0);
        chk("seq_pass", 32'(pass_a), 32'h1);
        chk("seq_cnt", 32'(cnt_a), 32'd127);
        chk("seq_pat_idle", 32'(pat_a), 32'h0);
        chk("seq_distinct", 32'($countones(seen)), 32'd127);
        chk("seq_no_zero", 32'(seen[0]), 32'h0);

        // Random responses, restarted from DONE twice: same signature each time
        exp_sig = 16'h0000;
        for (int k = 0; k < 127; k++) begin
            rnd[k]  = 2'($urandom_range(0, 3));
            exp_sig = misr_step(exp_sig, rnd[k]);
        end
        for (int rep = 0; rep < 2; rep++) begin
            start_a = 1'b1;
            tick();
            start_a = 1'b0;
            chk("restart_done_low", 32'(done_a), 32'h0);
            chk("restart_busy", 32'(busy_a), 32'h1);
            chk("restart_pat", 32'(pat_a), 32'h01);
            for (int k = 0; k < 127; k++) begin
                resp_a = rnd[k];
                tick();
            end
            resp_a = 2'b00;
            chk("rand_sig", 32'(sig_a), 32'(exp_sig));
            chk("rand_done", 32'(done_a), 32'h1);
            chk("rand_pass", 32'(pass_a), 32'(exp_sig == 16'h0000));
            chk("rand_cnt", 32'(cnt_a), 32'd127);
        end

        // Abort in RUN cycle 5
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int k = 0; k < 5; k++) begin
            resp_a = 2'b11;
            tick();
        end
        chk("pre_abort_cnt", 32'(cnt_a), 32'd5);
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        resp_a  = 2'b00;
        chk("abort_busy", 32'(busy_a), 32'h0);
        chk("abort_done", 32'(done_a), 32'h0);
        chk("abort_sig", 32'(sig_a), 32'h0);
        chk("abort_cnt", 32'(cnt_a), 32'h0);
        chk("abort_pat", 32'(pat_a), 32'h0);

        // start together with abort in IDLE
        start_a = 1'b1;
        abort_a = 1'b1;
        tick();
        start_a = 1'b0;
        abort_a = 1'b0;
        chk("coll_busy", 32'(busy_a), 32'h0);
        chk("coll_pat", 32'(pat_a), 32'h0);
        tick();
        chk("coll_busy_after", 32'(busy_a), 32'h0);

        // N=2 table: each vector restarts from the previous DONE
        for (int i = 0; i < 6; i++) begin
            start_b = 1'b1;
            tick();
            start_b = 1'b0;
            resp_b  = tbl[i].r0;
            chk("tbl_done_c0", 32'(done_b), 32'h0);
            tick();
            resp_b  = tbl[i].r1;
            chk("tbl_done_c1", 32'(done_b), 32'h0);
            tick();
            resp_b  = 2'b00;
            chk("tbl_done", 32'(done_b), 32'h1);
            chk("tbl_sig", 32'(sig_b), 32'(tbl[i].sig));
            chk("tbl_pass", 32'(pass_b), 32'(tbl[i].p));
            chk("tbl_cnt", 32'(cnt_b), 32'd2);
        end

        // Abort outranks completion on the last pattern
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        resp_b  = 2'b01;
        tick();
        abort_b = 1'b1;
        tick();
        abort_b = 1'b0;
        resp_b  = 2'b00;
        chk("abort_last_done", 32'(done_b), 32'h0);
        chk("abort_last_busy", 32'(busy_b), 32'h0);
        chk("abort_last_sig", 32'(sig_b), 32'h0);

        // N=1
        start_c = 1'b1;
        tick();
        start_c = 1'b0;
        resp_c  = 2'b11;
        chk("n1_busy", 32'(busy_c), 32'h1);
        tick();
        resp_c  = 2'b00;
        chk("n1_done", 32'(done_c), 32'h1);
        chk("n1_sig", 32'(sig_c), 32'h0003);
        chk("n1_cnt", 32'(cnt_c), 32'd1);

        // Behavioural CUT: golden run, then one output bit inverted
        for (int f = 0; f < 2; f++) begin
            fault_d = (f == 1);
            start_d = 1'b1;
            tick();
            start_d = 1'b0;
            repeat (N_D) tick();
            chk("cut_done", 32'(done_d), 32'h1);
            chk("cut_sig", 32'(sig_d), 32'(model_sig(N_D, fault_d)));
            chk("cut_pass", 32'(pass_d), (f == 0) ? 32'h1 : 32'h0);
        end
        fault_d = 1'b0;

        // Asynchronous reset mid-run
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        resp_a  = 2'b11;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_pat", 32'(pat_a), 32'h0);
        chk("async_busy", 32'(busy_a), 32'h0);
        chk("async_sig", 32'(sig_a), 32'h0);
        chk("async_cnt", 32'(cnt_a), 32'h0);
        chk("async_done_d", 32'(done_d), 32'h0);
        #2;
        rst_n  = 1'b1;
        resp_a = 2'b00;
        repeat (3) tick();
        chk("post_rst_busy", 32'(busy_a), 32'h0);
        chk("post_rst_pat", 32'(pat_a), 32'h0);
        chk("post_rst_done", 32'(done_a), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
